mem_stage_lsu: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. It consumes the registered MEM_* control and data signals and runs a req/ack transaction on the data bus. It stalls the pipeline until the transaction completes, then produces width-formatted, sign/zero-extended load data for the MEM/WB register. It also flags misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_stage_lsu.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns EX/MEM control into a req/ack bus transaction,
// stalls the pipeline while it is outstanding and formats the returned load data.
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_funct3,
  input  logic [31:0] MEM_ALU_Result,
  input  logic [31:0] MEM_Read_data_2,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic [31:0] MEM_Load_data,
  output logic        MEM_fault
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state;
  logic [7:0]  count;
  logic        timed_out;
  logic [2:0]  acc_funct3;
  logic [1:0]  acc_lane;
  logic        acc_load;

  logic        access;
  logic        is_store;
  logic        legal;
  logic        misaligned;
  logic        start;
  logic        reject;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;

  // A simultaneous read+write is treated as a store.
  always_comb begin
    access     = MEM_MemRead | MEM_MemWrite;
    is_store   = MEM_MemWrite;
    legal      = 1'b0;
    misaligned = 1'b0;
    case (MEM_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;
      default:                legal = 1'b0;
    endcase
    if (MEM_funct3[1:0] == 2'b01 && MEM_ALU_Result[0])
      misaligned = 1'b1;
    if (MEM_funct3[1:0] == 2'b10 && MEM_ALU_Result[1:0] != 2'b00)
      misaligned = 1'b1;
    start  = (state == IDLE) && access && legal && !misaligned;
    reject = (state == IDLE) && access && !(legal && !misaligned);
  end

  always_comb begin
    st_wdata = 32'h0;
    st_be    = 4'b0000;
    case (MEM_funct3[1:0])
      2'b00: begin
        st_wdata = {4{MEM_Read_data_2[7:0]}};
        st_be    = 4'b0001 << MEM_ALU_Result[1:0];
      end
      2'b01: begin
        st_wdata = {2{MEM_Read_data_2[15:0]}};
        st_be    = MEM_ALU_Result[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = MEM_Read_data_2;
        st_be    = 4'b1111;
      end
    endcase
  end

  function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                              input logic [2:0]  funct3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[8*lane +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'h0, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'h0, h};
      default: format_load = rdata;
    endcase
  endfunction

  assign mem_stall = start || (state == WAIT);
  assign MEM_fault = reject || (state == DONE && timed_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 8'h0;
      timed_out     <= 1'b0;
      acc_funct3    <= 3'b000;
      acc_lane      <= 2'b00;
      acc_load      <= 1'b0;
      dbus_req      <= 1'b0;
      dbus_we       <= 1'b0;
      dbus_addr     <= 32'h0;
      dbus_wdata    <= 32'h0;
      dbus_be       <= 4'b0000;
      MEM_Load_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          count     <= 8'h0;
          timed_out <= 1'b0;
          if (start) begin
            dbus_req   <= 1'b1;
            dbus_we    <= is_store;
            dbus_addr  <= {MEM_ALU_Result[31:2], 2'b00};
            dbus_wdata <= is_store ? st_wdata : 32'h0;
            dbus_be    <= is_store ? st_be : 4'b0000;
            acc_funct3 <= MEM_funct3;
            acc_lane   <= MEM_ALU_Result[1:0];
            acc_load   <= ~is_store;
            state      <= WAIT;
          end
        end
        WAIT: begin
          count <= count + 8'd1;
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            if (acc_load)
              MEM_Load_data <= format_load(dbus_rdata, acc_funct3, acc_lane);
            state <= DONE;
          end else if (count + 8'd1 == TIMEOUT_LIMIT) begin
            // Abort: a timed-out load returns zero rather than stale data.
            dbus_req  <= 1'b0;
            dbus_we   <= 1'b0;
            timed_out <= 1'b1;
            if (acc_load)
              MEM_Load_data <= 32'h0;
            state <= DONE;
          end
        end
        DONE: begin
          timed_out <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Table-driven bench for mem_stage_lsu with a scoreboard of expected bus/load results.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        MEM_MemRead;
  logic        MEM_MemWrite;
  logic [2:0]  MEM_funct3;
  logic [31:0] MEM_ALU_Result;
  logic [31:0] MEM_Read_data_2;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic [31:0] MEM_Load_data;
  logic        MEM_fault;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_load = 32'h0;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_funct3(MEM_funct3), .MEM_ALU_Result(MEM_ALU_Result),
    .MEM_Read_data_2(MEM_Read_data_2),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
    .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
    .mem_stall(mem_stall), .MEM_Load_data(MEM_Load_data), .MEM_fault(MEM_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    int          delay;
    logic        fault_now;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    logic        exp_timeout;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] load;
    logic        timeout;
    int          req_cycles;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic rd, logic wr, logic [2:0] f3, logic [31:0] addr,
                              logic [31:0] sdata, logic [31:0] rdata, int delay,
                              logic fault_now, logic [31:0] exp_addr, logic [3:0] exp_be,
                              logic [31:0] exp_wdata, logic [31:0] exp_load, logic exp_timeout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
    v.delay = delay; v.fault_now = fault_now; v.exp_addr = exp_addr; v.exp_be = exp_be;
    v.exp_wdata = exp_wdata; v.exp_load = exp_load; v.exp_timeout = exp_timeout;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    MEM_MemRead     = v.rd;
    MEM_MemWrite    = v.wr;
    MEM_funct3      = v.f3;
    MEM_ALU_Result  = v.addr;
    MEM_Read_data_2 = v.sdata;
  endtask

  task automatic clear_inputs();
    MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_funct3 = 3'b000;
    MEM_ALU_Result = 32'h0; MEM_Read_data_2 = 32'h0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   req_cycles;
    logic done;
    @(posedge clk); #1;
    apply_stimulus(v);
    @(negedge clk);
    if (v.fault_now) begin
      check_output("fault_same_cycle", {31'h0, MEM_fault}, 32'h1);
      check_output("fault_no_stall", {31'h0, mem_stall}, 32'h0);
      check_output("fault_no_req", {31'h0, dbus_req}, 32'h0);
      check_output("fault_load_held", MEM_Load_data, model_load);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      check_output("fault_no_req_after", {31'h0, dbus_req}, 32'h0);
      return;
    end
    check_output("start_stall", {31'h0, mem_stall}, 32'h1);
    check_output("start_no_fault", {31'h0, MEM_fault}, 32'h0);
    e.addr = v.exp_addr; e.we = v.wr; e.be = v.exp_be; e.wdata = v.exp_wdata;
    e.load = (v.rd && !v.wr) ? v.exp_load : model_load;
    e.timeout = v.exp_timeout;
    e.req_cycles = v.exp_timeout ? 4 : v.delay + 1;
    sb.push_back(e);
    req_cycles = 0;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(posedge clk); #1;
      dbus_ack   = (n == v.delay);
      dbus_rdata = dbus_ack ? v.rdata : 32'h5A5A5A5A;
      @(negedge clk);
      if (mem_stall) begin
        req_cycles++;
        check_output("wait_req", {31'h0, dbus_req}, 32'h1);
        check_output("wait_addr", dbus_addr, sb[0].addr);
        check_output("wait_we", {31'h0, dbus_we}, {31'h0, sb[0].we});
        check_output("wait_be", {28'h0, dbus_be}, {28'h0, sb[0].be});
        check_output("wait_wdata", dbus_wdata, sb[0].wdata);
      end else begin
        done = 1'b1;
      end
    end
    dbus_ack = 1'b0;
    if (!done) begin
      check_output("done_reached", 32'h0, 32'h1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check_output("req_cycles", req_cycles, e.req_cycles);
      check_output("done_req", {31'h0, dbus_req}, 32'h0);
      check_output("done_fault", {31'h0, MEM_fault}, {31'h0, e.timeout});
      check_output("done_load", MEM_Load_data, e.load);
      model_load = e.load;
    end
    clear_inputs();
    @(negedge clk);
    check_output("idle_load_hold", MEM_Load_data, model_load);
    check_output("idle_stall", {31'h0, mem_stall}, 32'h0);
  endtask

  initial begin
    clear_inputs();
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_output("rst_req", {31'h0, dbus_req}, 32'h0);
    check_output("rst_addr", dbus_addr, 32'h0);
    check_output("rst_be", {28'h0, dbus_be}, 32'h0);
    check_output("rst_load", MEM_Load_data, 32'h0);
    check_output("rst_stall_fault", {30'h0, mem_stall, MEM_fault}, 32'h0);

    //           rd   wr   f3      addr          sdata         rdata         dly flt  exp_addr      be       wdata         load          to
    vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hDEADBEEF, 2, 1'b0, 32'h0000_0200, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFFFF80, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF1234, 0, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h00000080, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000ABCD, 32'h0,        1, 1'b0, 32'h0000_0100, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h11,       32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 3'b000, 32'h0000_00F1, 32'h123456A7, 32'h0,        0, 1'b0, 32'h0000_00F0, 4'b0010, 32'hA7A7A7A7, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b001, 32'h0000_0206, 32'h0,        32'h80017FFF, 1, 1'b0, 32'h0000_0204, 4'b0000, 32'h0,        32'hFFFF8001, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b101, 32'h0000_0204, 32'h0,        32'h8001F00F, 0, 1'b0, 32'h0000_0204, 4'b0000, 32'h0,        32'h0000F00F, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 3'b010, 32'h0000_0010, 32'hCAFEF00D, 32'h0,        0, 1'b0, 32'h0000_0010, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h12345678, -1, 1'b0, 32'h0000_0400, 4'b0000, 32'h0,       32'h0,        1'b1));
    vecs.push_back(mk(1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h00007F00, 2, 1'b0, 32'h0000_0000, 4'b0000, 32'h0,        32'h0000007F, 1'b0));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset during the second WAIT cycle, then a stray ack.
    @(posedge clk); #1;
    MEM_MemRead = 1'b1; MEM_funct3 = 3'b010; MEM_ALU_Result = 32'h0000_0500;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rstw_req_before", {31'h0, dbus_req}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    dbus_ack = 1'b1;
    dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check_output("rstw_req", {31'h0, dbus_req}, 32'h0);
    check_output("rstw_addr", dbus_addr, 32'h0);
    check_output("rstw_load", MEM_Load_data, 32'h0);
    check_output("rstw_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    dbus_ack = 1'b0;
    @(negedge clk);
    check_output("rstw_ack_ignored", MEM_Load_data, 32'h0);
    check_output("rstw_idle_req", {31'h0, dbus_req}, 32'h0);
    check_output("rstw_idle_fault", {31'h0, MEM_fault}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
